// File: rtl/multi_req_counter_pkg.sv
// Shared types and counter step helper for multi_req_counter.
// The step helper works on 32-bit values so it serves any CNT_W up to 32.
package multi_req_counter_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] val;
        logic        lim;
    } step_t;

    function automatic step_t sat_step(
        input logic [31:0] value,
        input logic [31:0] max_v,
        input logic        dir,
        input logic        saturate
    );
        step_t r;
        r.lim = 1'b0;
        r.val = value;
        if (!dir) begin
            if (value == max_v) begin
                r.lim = 1'b1;
                r.val = saturate ? max_v : 32'd0;
            end else begin
                r.val = value + 32'd1;
            end
        end else begin
            if (value == 32'd0) begin
                r.lim = 1'b1;
                r.val = saturate ? 32'd0 : max_v;
            end else begin
                r.val = value - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_req_counter_arb.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Reusable by any hub that keeps its own registered pointer.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [PTR_W-1:0]  idx_o,
    output logic              valid_o
);

    always_comb begin
        int j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/multi_req_counter.sv
// Sticky per-channel button requests arbitrated round-robin onto one
// shared up/down counter engine that stays busy BUSY_CYC cycles per update.
module multi_req_counter
    import multi_req_counter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 4,
    parameter int BUSY_CYC = 2,
    parameter int SATURATE = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] button_i,
    input  logic [NUM_CH-1:0] dir_i,
    output logic [CNT_W-1:0]  counter_o,
    output logic [NUM_CH-1:0] grant_o,
    output logic [NUM_CH-1:0] pend_o,
    output logic              busy_o,
    output logic              limit_o,
    output logic [NUM_CH-1:0] drop_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W  = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;
    localparam logic [31:0] MAX_V = 32'((64'd1 << CNT_W) - 64'd1);

    logic [NUM_CH-1:0] r_btn_q;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_grant;
    logic [NUM_CH-1:0] r_drop;
    state_e            r_state;
    logic              r_dir;
    logic [BC_W-1:0]   r_busy_cnt;
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_limit;
    logic              r_busy;

    logic [NUM_CH-1:0] w_edge;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_gnt;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_nxt;
    logic              w_valid;
    logic              w_done;
    step_t             w_step;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req_i   (r_pend),
        .ptr_i   (r_ptr),
        .gnt_o   (w_gnt),
        .idx_o   (w_idx),
        .valid_o (w_valid)
    );

    assign w_edge = button_i & ~r_btn_q;
    assign w_done = (r_state == BUSY) && (r_busy_cnt == '0);
    assign w_clr  = w_done ? r_grant : '0;
    assign w_nxt  = (w_idx == PTR_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
    assign w_step = sat_step(32'(r_cnt), MAX_V, r_dir, SATURATE != 0);

    // A fresh edge always re-arms pend, so set beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_btn_q    <= '0;
            r_pend     <= '0;
            r_grant    <= '0;
            r_drop     <= '0;
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_busy_cnt <= '0;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_limit    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_btn_q <= button_i;
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            r_drop  <= w_edge & r_pend & ~w_clr;
            r_limit <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant    <= w_gnt;
                        r_dir      <= dir_i[w_idx];
                        r_busy_cnt <= BC_W'(BUSY_CYC - 1);
                        r_ptr      <= w_nxt;
                        r_busy     <= 1'b1;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_busy_cnt != '0) begin
                        r_busy_cnt <= r_busy_cnt - 1'b1;
                    end else begin
                        r_cnt   <= w_step.val[CNT_W-1:0];
                        r_limit <= w_step.lim;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign counter_o = r_cnt;
    assign grant_o   = r_grant;
    assign pend_o    = r_pend;
    assign busy_o    = r_busy;
    assign limit_o   = r_limit;
    assign drop_o    = r_drop;

endmodule

// File: tb/tb_multi_req_counter.sv
// Directed bench for multi_req_counter: wrapping and saturating copies
// share one stimulus stream.
module tb_multi_req_counter;

    logic       clk;
    logic       rst_n;
    logic [3:0] button;
    logic [3:0] dir;

    logic [3:0] cnt,   cnt_s;
    logic [3:0] gnt,   gnt_s;
    logic [3:0] pend,  pend_s;
    logic       busy,  busy_s;
    logic       lim,   lim_s;
    logic [3:0] drop,  drop_s;

    int n_cmp = 0;
    int n_err = 0;

    multi_req_counter #(
        .NUM_CH(4), .CNT_W(4), .BUSY_CYC(2), .SATURATE(0)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .button_i  (button),
        .dir_i     (dir),
        .counter_o (cnt),
        .grant_o   (gnt),
        .pend_o    (pend),
        .busy_o    (busy),
        .limit_o   (lim),
        .drop_o    (drop)
    );

    multi_req_counter #(
        .NUM_CH(4), .CNT_W(4), .BUSY_CYC(2), .SATURATE(1)
    ) dut_s (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .button_i  (button),
        .dir_i     (dir),
        .counter_o (cnt_s),
        .grant_o   (gnt_s),
        .pend_o    (pend_s),
        .busy_o    (busy_s),
        .limit_o   (lim_s),
        .drop_o    (drop_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        button = '0;
        rst_n  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        button = '0;
        dir    = '0;
        rst_n  = 1'b0;
        #1;
        do_reset();
        chk("rst_cnt",  32'(cnt),  0);
        chk("rst_gnt",  32'(gnt),  0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lim",  32'(lim),  0);
        chk("rst_drop", 32'(drop), 0);

        // single request, latency check
        button = 4'b0001;
        step();
        button = '0;
        chk("t1_pend_c1", 32'(pend), 4'b0001);
        chk("t1_busy_c1", 32'(busy), 0);
        step();
        chk("t1_busy_c2", 32'(busy), 1);
        chk("t1_gnt_c2",  32'(gnt),  4'b0001);
        step();
        chk("t1_busy_c3", 32'(busy), 1);
        chk("t1_gnt_c3",  32'(gnt),  4'b0001);
        step();
        chk("t1_cnt_c4",  32'(cnt),  1);
        chk("t1_pend_c4", 32'(pend), 0);
        chk("t1_busy_c4", 32'(busy), 0);

        // four simultaneous requests served 0,1,2,3
        do_reset();
        button = 4'b1111;
        step();
        button = '0;
        chk("t2_pend", 32'(pend), 4'b1111);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("t2_gnt", 32'(gnt), 32'(1 << k));
            step();
            step();
            chk("t2_cnt",  32'(cnt),  32'(k + 1));
            chk("t2_idle", 32'(busy), 0);
            chk("t2_gnt0", 32'(gnt),  0);
            step();
        end
        chk("t2_final", 32'(cnt), 4);

        // pointer wrapped to 0: ch0 beats ch3
        button = 4'b1001;
        step();
        button = '0;
        step();
        chk("t3_first",  32'(gnt), 4'b0001);
        step();
        step();
        step();
        chk("t3_second", 32'(gnt), 4'b1000);
        step();
        step();
        chk("t3_cnt", 32'(cnt), 6);

        // wrap vs saturate
        do_reset();
        for (int k = 0; k < 15; k++) begin
            button = 4'b0001;
            step();
            button = '0;
            step();
            step();
            step();
        end
        chk("t4_pre",   32'(cnt),   15);
        chk("t4_pre_s", 32'(cnt_s), 15);
        chk("t4_pre_l", 32'(lim),   0);
        button = 4'b0001;
        step();
        button = '0;
        step();
        step();
        step();
        chk("t4_wrap",    32'(cnt),    0);
        chk("t4_lim",     32'(lim),    1);
        chk("t4_sat",     32'(cnt_s),  15);
        chk("t4_sat_lim", 32'(lim_s),  1);
        chk("t4_sat_pnd", 32'(pend_s), 0);
        step();
        chk("t4_lim_once", 32'(lim),   0);
        chk("t4_slim_one", 32'(lim_s), 0);

        // decrement from 0 wraps to max
        dir    = 4'b0001;
        button = 4'b0001;
        step();
        button = '0;
        step();
        step();
        step();
        chk("t5_dec_wrap", 32'(cnt), 15);
        chk("t5_dec_lim",  32'(lim), 1);

        // mixed directions: ch1 down first (ptr=1), then ch0 up
        dir    = 4'b0010;
        button = 4'b0011;
        step();
        button = '0;
        step();
        chk("t6_gnt1", 32'(gnt), 4'b0010);
        step();
        step();
        chk("t6_mid", 32'(cnt), 14);
        step();
        chk("t6_gnt0", 32'(gnt), 4'b0001);
        step();
        step();
        chk("t6_net", 32'(cnt), 15);
        chk("t6_lim", 32'(lim), 0);
        dir = '0;

        // second edge on ch1 while pending: dropped
        do_reset();
        button = 4'b0011;
        step();
        button = '0;
        step();
        button = 4'b0010;
        step();
        button = '0;
        chk("t7_drop",  32'(drop), 4'b0010);
        step();
        chk("t7_drop0", 32'(drop), 0);
        chk("t7_cnt1",  32'(cnt),  1);
        step();
        step();
        step();
        chk("t7_cnt2",  32'(cnt),  2);
        chk("t7_pend",  32'(pend), 0);
        step();
        step();
        step();
        chk("t7_one",   32'(cnt),  2);
        chk("t7_busy",  32'(busy), 0);

        // edge in the clear cycle: set wins
        button = 4'b0010;
        step();
        button = '0;
        step();
        step();
        button = 4'b0010;
        step();
        button = '0;
        chk("t8_cnt",   32'(cnt),  3);
        chk("t8_pend",  32'(pend), 4'b0010);
        chk("t8_drop",  32'(drop), 0);
        step();
        step();
        step();
        chk("t8_cnt2",  32'(cnt),  4);
        chk("t8_pend0", 32'(pend), 0);

        // async reset in the second busy cycle
        button = 4'b0001;
        step();
        button = '0;
        step();
        step();
        chk("t9_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t9_cnt",  32'(cnt),  0);
        chk("t9_gnt",  32'(gnt),  0);
        chk("t9_busy0", 32'(busy), 0);
        chk("t9_pend", 32'(pend), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("t9_post_cnt",  32'(cnt),  0);
        chk("t9_post_busy", 32'(busy), 0);
        chk("t9_post_pend", 32'(pend), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
